soc_event_bridge: RTL and testbench
===================================

# soc_event_bridge

Parametrised multi-channel event bridge from SoC peripherals toward the cluster event unit. It arbitrates `NB_CH` valid/ack event sources round-robin and writes event IDs into a `DEPTH`-entry buffer. The buffer is exposed through a Gray-coded write pointer, and consumption is tracked through a Gray-coded read pointer arriving from the consumer domain. It generalises the fixed single-source cluster event channel: channel count, buffer depth, synchroniser length and full policy are all parameters, and it adds per-channel enables and a drop counter.

## Interface
- `NB_CH`, default 4: number of event sources, ≥1.
- `EVNT_WIDTH`, default 8: event ID width.
- `DEPTH`, default 8: buffer entries, power of 2, ≥2.
- `SYNC_STAGES`, default 2: flops on the `rd_ptr_i` synchroniser, ≥2.
- `DROP_ON_FULL`, default 0: full policy; 0 = back-pressure, 1 = ack and discard.
- `CNT_WIDTH`, default 16: drop counter width.
- `PTR_W`, derived: `$clog2(DEPTH)+1`.
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk_i`  in  1  SoC clock; all state on rising edge.
- `rst_ni`  in  1  synchronous active-low reset.
- `evt_valid_i`  in  `NB_CH`  per-channel event request.
- `evt_id_i`  in  `NB_CH*EVNT_WIDTH`  per-channel event ID; channel c occupies bits [c*EVNT_WIDTH +: EVNT_WIDTH].
- `ch_en_i`  in  `NB_CH`  per-channel enable.
- `evt_ack_o`  out  `NB_CH`  one-hot acceptance, combinational.
- `rd_ptr_i`  in  `PTR_W`  consumer read pointer, Gray, asynchronous.
- `wr_ptr_o`  out  `PTR_W`  write pointer, Gray, registered.
- `buf_data_o`  out  `DEPTH*EVNT_WIDTH`  buffer contents; entry i occupies bits [i*EVNT_WIDTH +: EVNT_WIDTH].
- `full_o`  out  1  buffer full, using the synchronised read pointer.
- `empty_o`  out  1  buffer empty, using the synchronised read pointer.
- `drop_cnt_o`  out  `CNT_WIDTH`  saturating count of discarded events.
- `drop_clr_i`  in  1  clears the drop counter.

## Operation
- **Read-pointer synchroniser:** `rd_ptr_i` passes through `SYNC_STAGES` flops, then is converted Gray→binary to give `rd_bin`.
- **Write pointer:** `wr_bin` is `PTR_W` bits and wraps naturally mod 2^PTR_W. `wr_ptr_o` is the registered Gray encoding of `wr_bin`.
- **Full/empty:**
  - `full_o` = ((`wr_bin` − `rd_bin`) mod 2^PTR_W == `DEPTH`).
  - `empty_o` = (`wr_bin` == `rd_bin`).
- **Request set:** req = `evt_valid_i` & `ch_en_i`. Disabled channels are never acked, regardless of `evt_valid_i`.
- **Arbitration:** round-robin with priority pointer `prio`. The winner is the first requesting channel at or after `prio`, modulo `NB_CH`.
- **Accept, not full:** ack the winner; write `buf[wr_bin[PTR_W-2:0]]` ← winner's ID; increment `wr_bin`; set `prio` ← winner+1.
- **Full, `DROP_ON_FULL`=0:** all acks 0; `prio` and the buffer hold.
- **Full, `DROP_ON_FULL`=1:** ack the winner and advance `prio`; the buffer and `wr_bin` are unchanged; `drop_cnt` increments, saturating at 2^CNT_WIDTH−1.
- **Drop-counter clear:** `drop_clr_i` takes priority. If a drop and a clear occur in the same cycle, the counter becomes 0.
- **Handshake:** a source holds `evt_valid_i` and its ID stable until it sees its ack. The source may present a new ID in the cycle after the ack.

## Timing
- Reset values: `wr_bin`=0, `wr_ptr_o`=0, all synchroniser flops 0, `prio`=0, `drop_cnt_o`=0, `full_o`=0, `empty_o`=1, buffer contents 0.
- Reset clears everything in one cycle; the consumer must be reset jointly with this block.
- `evt_ack_o` is asserted in the same cycle T as the request.
- The written entry and the new `wr_ptr_o` are both visible at T+1, updated on the same edge.
- A `rd_ptr_i` change is reflected in `full_o`/`empty_o` after `SYNC_STAGES` cycles.
- Throughput: one event per cycle when not full.
- Pointer wrap needs no special case; `full_o` is still correct when `wr_bin` < `rd_bin` numerically.

## Structure
- Package `soc_evt_pkg` contains:
  - `bin2gray` and `gray2bin` functions, parametrised by width;
  - the `PTR_W` computation.
- Sub-module `soc_evt_rr_arb`: inputs `NB_CH` requests and `prio`; outputs a one-hot grant and the winner index.
- The top level holds the synchroniser, pointer logic, buffer and drop counter.

## Test plan
- **Reset:** drive `rst_ni`=0 for 2 cycles → `wr_ptr_o`=0, `empty_o`=1, `full_o`=0, acks 0, `drop_cnt_o`=0.
- **Single channel:** channel 0 sends IDs 0x11 then 0x22, `rd_ptr_i`=0 → acks at T and T+1; buffer entry0=0x11, entry1=0x22; `wr_ptr_o` goes 1 then 3 (Gray).
- **Arbitration fairness:** channels 0–3 all valid continuously, `ch_en_i`=4'b1011 → ack order 0,1,3,0,1,3…; channel 2 never acked.
- **Back-pressure:** `DEPTH`=8, `rd_ptr_i`=0; 8 writes → `wr_ptr_o`=4'b1100, `full_o`=1, ack 0. Then `rd_ptr_i`=4'b0001 → after 2 cycles `full_o`=0; the next ID lands in entry 0.
- **Drop mode:** `DROP_ON_FULL`=1, buffer full, 3 more events → each acked, `drop_cnt_o`=3, buffer unchanged. Then a drop with `drop_clr_i` in the same cycle → `drop_cnt_o`=0.
- **Wrap-around:** 20 events with the consumer tracking 2 entries behind → `wr_bin` wraps 15→0, `full_o` never asserts, entry i holds event (16+i) after the wrap.

Source files
------------

// File: rtl/soc_evt_pkg.sv
// Shared helpers for the SoC event bridge.
// - ptr_width: pointer width (index bits plus one wrap bit) for a given buffer depth.
// - bin2gray / gray2bin: Gray conversions on a 32-bit carrier. Callers zero-extend a
//   narrower pointer into the carrier and truncate the result back. Both
//   conversions are exact for any width up to 32 bits, because zero upper bits stay
//   zero in both directions.
package soc_evt_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Combinational round-robin arbiter.
// - req_i   : per-channel request
// - prio_i  : index of the channel with the highest priority this cycle
// - gnt_o   : one-hot grant; all zeros when there is no request
// - idx_o   : index of the granted channel
// - valid_o : set when some channel is granted
module soc_evt_rr_arb #(
    parameter int unsigned NB_CH = 4,
    localparam int unsigned IDX_W = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic [NB_CH-1:0] req_i,
    input  logic [IDX_W-1:0] prio_i,
    output logic [NB_CH-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    localparam logic [IDX_W:0] NB_CH_W = (IDX_W + 1)'(NB_CH);

    logic [IDX_W:0] cand;

    // Scan from prio_i upward, wrapping modulo NB_CH. The first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NB_CH; i++) begin
            cand = {1'b0, prio_i} + (IDX_W + 1)'(i);
            if (cand >= NB_CH_W) begin
                cand = cand - NB_CH_W;
            end
            if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/soc_event_bridge.sv
// Multi-channel event bridge. Round-robin arbitration between NB_CH peripheral
// sources feeds a DEPTH-entry buffer. A consumer in another clock domain reads
// the buffer.
// - evt_valid_i / evt_id_i / ch_en_i : per-channel event requests, IDs and enables
// - evt_ack_o  : one-hot, combinational acceptance
// - rd_ptr_i   : consumer Gray read pointer (asynchronous, synchronised here)
// - wr_ptr_o   : registered Gray write pointer
// - buf_data_o : flat view of all buffer entries
// - full_o / empty_o : occupancy derived from the synchronised read pointer
// - drop_cnt_o / drop_clr_i : saturating discard counter and its clear
module soc_event_bridge
    import soc_evt_pkg::*;
#(
    parameter int unsigned NB_CH        = 4,
    parameter int unsigned EVNT_WIDTH   = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter bit          DROP_ON_FULL = 1'b0,
    parameter int unsigned CNT_WIDTH    = 16,
    localparam int unsigned PTR_W       = ptr_width(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NB_CH-1:0]            evt_valid_i,
    input  logic [NB_CH*EVNT_WIDTH-1:0] evt_id_i,
    input  logic [NB_CH-1:0]            ch_en_i,
    output logic [NB_CH-1:0]            evt_ack_o,
    input  logic [PTR_W-1:0]            rd_ptr_i,
    output logic [PTR_W-1:0]            wr_ptr_o,
    output logic [DEPTH*EVNT_WIDTH-1:0] buf_data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [CNT_WIDTH-1:0]        drop_cnt_o,
    input  logic                        drop_clr_i
);

    localparam int unsigned IDX_W = (NB_CH > 1) ? $clog2(NB_CH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [PTR_W-1:0]      sync_q [SYNC_STAGES];
    logic [PTR_W-1:0]      sync_d [SYNC_STAGES];
    logic [PTR_W-1:0]      rd_bin;
    logic [PTR_W-1:0]      wr_bin_q, wr_bin_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]      prio_q, prio_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic [EVNT_WIDTH-1:0] mem_q [DEPTH];
    logic [EVNT_WIDTH-1:0] mem_d [DEPTH];
    logic [EVNT_WIDTH-1:0] id_arr [NB_CH];

    logic [NB_CH-1:0] req;
    logic [NB_CH-1:0] gnt;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             accept;
    logic             drop;

    for (genvar c = 0; c < NB_CH; c++) begin : g_id_unpack
        assign id_arr[c] = evt_id_i[c*EVNT_WIDTH +: EVNT_WIDTH];
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_buf_pack
        assign buf_data_o[e*EVNT_WIDTH +: EVNT_WIDTH] = mem_q[e];
    end

    assign req = evt_valid_i & ch_en_i;

    soc_evt_rr_arb #(
        .NB_CH (NB_CH)
    ) u_arb (
        .req_i   (req),
        .prio_i  (prio_q),
        .gnt_o   (gnt),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign rd_bin  = PTR_W'(gray2bin(GRAY_MAX_W'(sync_q[SYNC_STAGES-1])));
    // Modular difference keeps full correct across pointer wrap.
    assign full_o  = ((wr_bin_q - rd_bin) == PTR_W'(DEPTH));
    assign empty_o = (wr_bin_q == rd_bin);

    assign accept    = win_valid && !full_o;
    assign drop      = win_valid && full_o && DROP_ON_FULL;
    assign evt_ack_o = (accept || drop) ? gnt : '0;

    assign wr_ptr_o   = wr_ptr_q;
    assign drop_cnt_o = drop_cnt_q;

    always_comb begin
        sync_d[0] = rd_ptr_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        wr_bin_d   = wr_bin_q;
        prio_d     = prio_q;
        drop_cnt_d = drop_cnt_q;
        mem_d      = mem_q;

        if (accept) begin
            mem_d[wr_bin_q[PTR_W-2:0]] = id_arr[win_idx];
            wr_bin_d = wr_bin_q + 1'b1;
        end

        if (accept || drop) begin
            prio_d = (win_idx == IDX_W'(NB_CH - 1)) ? '0 : win_idx + 1'b1;
        end

        // A clear wins over a simultaneous drop.
        if (drop_clr_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end

        wr_ptr_d = PTR_W'(bin2gray(GRAY_MAX_W'(wr_bin_d)));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_bin_q   <= '0;
            wr_ptr_q   <= '0;
            prio_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            mem_q      <= mem_d;
            wr_bin_q   <= wr_bin_d;
            wr_ptr_q   <= wr_ptr_d;
            prio_q     <= prio_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_soc_event_bridge.sv
// Self-checking bench for soc_event_bridge with default parameters, plus a second
// instance in discard-on-full mode. A behavioural model predicts the acks and the
// buffer writes. Each predicted write is queued and then checked against the
// buffer after the clock edge.
module tb_soc_event_bridge;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Back-pressure instance.
    logic [3:0]  evt_valid, ch_en, evt_ack, rd_ptr, wr_ptr;
    logic [7:0]  ids [4];
    logic [31:0] evt_id;
    logic [63:0] buf_data;
    logic        full, empty, drop_clr;
    logic [15:0] drop_cnt;

    assign evt_id = {ids[3], ids[2], ids[1], ids[0]};

    soc_event_bridge u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .evt_valid_i (evt_valid),
        .evt_id_i    (evt_id),
        .ch_en_i     (ch_en),
        .evt_ack_o   (evt_ack),
        .rd_ptr_i    (rd_ptr),
        .wr_ptr_o    (wr_ptr),
        .buf_data_o  (buf_data),
        .full_o      (full),
        .empty_o     (empty),
        .drop_cnt_o  (drop_cnt),
        .drop_clr_i  (drop_clr)
    );

    // Discard-on-full instance.
    logic [3:0]  d_valid, d_en, d_ack, d_wr_ptr;
    logic [31:0] d_id;
    logic [63:0] d_buf;
    logic        d_full, d_empty, d_clr;
    logic [15:0] d_cnt;

    soc_event_bridge #(
        .DROP_ON_FULL (1'b1)
    ) u_dut_drop (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .evt_valid_i (d_valid),
        .evt_id_i    (d_id),
        .ch_en_i     (d_en),
        .evt_ack_o   (d_ack),
        .rd_ptr_i    (4'd0),
        .wr_ptr_o    (d_wr_ptr),
        .buf_data_o  (d_buf),
        .full_o      (d_full),
        .empty_o     (d_empty),
        .drop_cnt_o  (d_cnt),
        .drop_clr_i  (d_clr)
    );

    typedef struct packed {
        logic [2:0] slot;
        logic [7:0] id;
    } sb_entry_t;

    sb_entry_t   sb_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Model state
    logic [3:0]  m_wr;
    logic [3:0]  m_rd_pipe [2];
    int          m_prio;
    logic [3:0]  ack_seen;
    logic        full_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // One clock cycle on the back-pressure instance; rd_bin is the consumer pointer.
    task automatic step(input logic [3:0] valid, input logic [3:0] en, input logic [3:0] rd_bin);
        logic [3:0] req;
        logic [3:0] exp_ack;
        logic       m_full;
        int         win;
        sb_entry_t  e;
        evt_valid = valid;
        ch_en     = en;
        rd_ptr    = to_gray(rd_bin);
        #1;
        m_full = ((m_wr - m_rd_pipe[1]) == 4'd8);
        check("full", full, m_full);
        check("empty", empty, m_wr == m_rd_pipe[1]);
        full_seen = full_seen | full;
        req     = valid & en;
        exp_ack = '0;
        win     = -1;
        for (int i = 0; i < 4; i++) begin
            if (win < 0 && req[(m_prio + i) % 4]) win = (m_prio + i) % 4;
        end
        if (win >= 0 && !m_full) begin
            exp_ack[win] = 1'b1;
            sb_q.push_back('{slot: m_wr[2:0], id: ids[win]});
            m_wr   = m_wr + 4'd1;
            m_prio = (win + 1) % 4;
        end
        check("ack", evt_ack, exp_ack);
        ack_seen = ack_seen | evt_ack;
        @(posedge clk);
        #1;
        m_rd_pipe[1] = m_rd_pipe[0];
        m_rd_pipe[0] = rd_bin;
        check("wr_ptr", wr_ptr, to_gray(m_wr));
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("buf_entry", buf_data[e.slot*8 +: 8], e.id);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        evt_valid = '0;
        ch_en     = '0;
        rd_ptr    = '0;
        drop_clr  = 1'b0;
        for (int i = 0; i < 4; i++) ids[i] = '0;
        d_valid   = '0;
        d_en      = '0;
        d_id      = '0;
        d_clr     = 1'b0;
        m_wr      = '0;
        m_rd_pipe[0] = '0;
        m_rd_pipe[1] = '0;
        m_prio    = 0;
        ack_seen  = '0;
        full_seen = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_wr_ptr", wr_ptr, 4'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_ack", evt_ack, 4'd0);
        check("rst_drop_cnt", drop_cnt, 16'd0);
        check("rst_buf", buf_data, 64'd0);
        check("rst_drop_inst_cnt", d_cnt, 16'd0);
        check("rst_drop_inst_empty", d_empty, 1'b1);

        // Single channel, two back-to-back events.
        ids[0] = 8'h11;
        step(4'b0001, 4'hF, 4'd0);
        check("single_wr_ptr1", wr_ptr, 4'b0001);
        ids[0] = 8'h22;
        step(4'b0001, 4'hF, 4'd0);
        check("single_wr_ptr2", wr_ptr, 4'b0011);
        check("single_entries", buf_data[15:0], 16'h2211);

        // Fairness with channel 2 disabled; fills the buffer to exactly 8.
        for (int i = 0; i < 4; i++) ids[i] = 8'(8'h30 + i);
        ack_seen = '0;
        repeat (6) step(4'hF, 4'b1011, 4'd0);
        check("fair_ch2_never", ack_seen[2], 1'b0);
        check("fair_others_acked", ack_seen[1:0], 2'b11);

        // Back-pressure.
        step(4'hF, 4'b1011, 4'd0);
        check("bp_wr_ptr", wr_ptr, 4'b1100);
        check("bp_full", full, 1'b1);
        check("bp_ack", evt_ack, 4'd0);
        step(4'h0, 4'hF, 4'd1);
        check("bp_sync_lag", full, 1'b1);
        step(4'h0, 4'hF, 4'd1);
        check("bp_release", full, 1'b0);
        ids[0] = 8'h5A;
        step(4'b0001, 4'hF, 4'd1);
        check("bp_entry0", buf_data[7:0], 8'h5A);

        // Wrap-around with the consumer two entries behind.
        step(4'h0, 4'hF, 4'd7);
        step(4'h0, 4'hF, 4'd7);
        full_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ids[1] = 8'(8'h80 + k);
            step(4'b0010, 4'hF, 4'(m_wr - 4'd2));
        end
        check("wrap_no_full", full_seen, 1'b0);
        check("wrap_wr_ptr", wr_ptr, 4'b1011);
        check("wrap_entry0", buf_data[7:0], 8'h8F);
        evt_valid = '0;

        // Discard-on-full instance: fill from channel 2.
        d_en    = 4'hF;
        d_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            d_id[23:16] = 8'(8'hA0 + k);
            #1;
            check("drop_fill_ack", d_ack, 4'b0100);
            @(posedge clk);
            #1;
        end
        check("drop_full", d_full, 1'b1);
        check("drop_fill_wr_ptr", d_wr_ptr, 4'b1100);
        d_id[23:16] = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("drop_ack", d_ack, 4'b0100);
            @(posedge clk);
            #1;
        end
        check("drop_cnt3", d_cnt, 16'd3);
        check("drop_buf_held", d_buf, 64'hA7A6A5A4A3A2A1A0);
        check("drop_wr_ptr_held", d_wr_ptr, 4'b1100);
        d_clr = 1'b1;
        #1;
        check("drop_clr_ack", d_ack, 4'b0100);
        @(posedge clk);
        #1;
        d_clr = 1'b0;
        check("drop_clr_wins", d_cnt, 16'd0);
        @(posedge clk);
        #1;
        check("drop_after_clr", d_cnt, 16'd1);
        d_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
